// File: rtl/vls_pkg.sv
// ---------------------------------------------------------------------------
// vls_pkg
// Shared types and constants for the vector lane sequencer.
//   state_t      : sequencer FSM states
//   opclass_t    : instruction class decoded from controlUnit outputs
//   decode_class : priority decode HIST > VST > VLD > VALU > NONE
//   exec_state   : first execution state entered for a given class
// ---------------------------------------------------------------------------
package vls_pkg;

  localparam int NUM_LANES_DEF = 8;
  localparam int LANE_W_DEF    = $clog2(NUM_LANES_DEF);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VALU,
    ST_HIST_RD,
    ST_HIST_WR,
    ST_MEM,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_VALU,
    OP_VLD,
    OP_VST,
    OP_HIST
  } opclass_t;

  // Histogram updates win over stores, stores over vector loads, and
  // anything without a vector flavour is a scalar op that we ignore.
  function automatic opclass_t decode_class(input logic vectorWrite,
                                            input logic histogramWrite,
                                            input logic memWrite,
                                            input logic memtoReg);
    opclass_t cls;
    cls = OP_NONE;
    if (histogramWrite)                cls = OP_HIST;
    else if (memWrite)                 cls = OP_VST;
    else if (vectorWrite && memtoReg)  cls = OP_VLD;
    else if (vectorWrite)              cls = OP_VALU;
    return cls;
  endfunction

  // Loads and stores share the memory state; the class register tells
  // them apart.
  function automatic state_t exec_state(input opclass_t cls);
    state_t st;
    case (cls)
      OP_VALU:       st = ST_VALU;
      OP_HIST:       st = ST_HIST_RD;
      OP_VLD,
      OP_VST:        st = ST_MEM;
      default:       st = ST_IDLE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/lane_next_finder.sv
// ---------------------------------------------------------------------------
// lane_next_finder
// Combinational search for the lowest set mask bit at or above a start lane.
//   mask_i  : active-lane mask
//   cur_i   : current lane index
//   incl_i  : 1 = cur_i itself may be returned, 0 = strictly above cur_i
//   next_o  : index of the lane found (0 when none)
//   found_o : a qualifying lane exists
// ---------------------------------------------------------------------------
module lane_next_finder #(
  parameter int NUM_LANES = 8,
  parameter int LANE_W    = $clog2(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0] mask_i,
  input  logic [LANE_W-1:0]    cur_i,
  input  logic                 incl_i,
  output logic [LANE_W-1:0]    next_o,
  output logic                 found_o
);

  // Scan from the top lane down so the last hit written is the lowest one.
  // Lanes at or below the current index are never candidates for an advance,
  // which is what keeps the lane index from wrapping.
  always_comb begin
    next_o  = '0;
    found_o = 1'b0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (mask_i[i] && ((i > int'(cur_i)) || (incl_i && (i == int'(cur_i))))) begin
        next_o  = LANE_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vector_lane_sequencer.sv
// ---------------------------------------------------------------------------
// vector_lane_sequencer
// Multi-cycle sequencer sitting between controlUnit decode outputs and the
// vector / histogram datapath. Vector-class instructions freeze fetch/decode
// while the active lanes are stepped through one at a time; scalar
// instructions pass straight through.
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   issue_valid     : decode holds a valid instruction
//   VectorWrite, HistogramWrite, MemWrite, MemtoReg : controlUnit decode
//   lane_mask       : active lanes of the issued instruction
//   mem_ack         : memory accepted/returned the current lane access
//   flush           : synchronous abort (branch taken)
//   stall           : freeze PC, fetch and decode
//   busy            : sequencer not idle
//   lane_sel        : current lane index
//   lane_we         : vector register file lane write
//   hist_rd/hist_we : histogram read / write phase
//   mem_req/mem_we  : data memory request / request is a store
//   done            : one-cycle completion pulse
// ---------------------------------------------------------------------------
module vector_lane_sequencer
  import vls_pkg::*;
#(
  parameter int NUM_LANES = NUM_LANES_DEF,
  parameter int LANE_W    = $clog2(NUM_LANES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  input  logic                 VectorWrite,
  input  logic                 HistogramWrite,
  input  logic                 MemWrite,
  input  logic                 MemtoReg,
  input  logic [NUM_LANES-1:0] lane_mask,
  input  logic                 mem_ack,
  input  logic                 flush,
  output logic                 stall,
  output logic                 busy,
  output logic [LANE_W-1:0]    lane_sel,
  output logic                 lane_we,
  output logic                 hist_rd,
  output logic                 hist_we,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 done
);

  state_t                state_q, state_d;
  opclass_t              class_q, class_d;
  logic [NUM_LANES-1:0]  mask_q, mask_d;
  logic [LANE_W-1:0]     lane_q, lane_d;

  opclass_t              inClass;
  logic                  accept;
  logic                  advance;

  logic [NUM_LANES-1:0]  findMask;
  logic [LANE_W-1:0]     findCur;
  logic                  findIncl;
  logic [LANE_W-1:0]     findNext;
  logic                  findFound;

  assign inClass = decode_class(VectorWrite, HistogramWrite, MemWrite, MemtoReg);

  // Reset is folded in so that stall cannot leak out while rst is held
  // with an instruction waiting in decode.
  assign accept = (state_q == ST_IDLE) && issue_valid && (inClass != OP_NONE)
                  && !flush && !rst;

  // One finder serves both jobs: in IDLE it picks the first lane of the
  // incoming mask (current lane included), otherwise it looks strictly
  // above the lane being worked on in the latched mask.
  assign findMask = (state_q == ST_IDLE) ? lane_mask : mask_q;
  assign findCur  = (state_q == ST_IDLE) ? '0 : lane_q;
  assign findIncl = (state_q == ST_IDLE);

  lane_next_finder #(
    .NUM_LANES (NUM_LANES),
    .LANE_W    (LANE_W)
  ) u_finder (
    .mask_i  (findMask),
    .cur_i   (findCur),
    .incl_i  (findIncl),
    .next_o  (findNext),
    .found_o (findFound)
  );

  // State and latched instruction context. Everything returns to the idle
  // picture immediately when rst rises, so all strobes drop at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      class_q <= OP_NONE;
      mask_q  <= '0;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      mask_q  <= mask_d;
      lane_q  <= lane_d;
    end
  end

  // Next-state logic. Each exec state raises 'advance' when its lane is
  // finished; the shared block after the case then moves to the next set
  // lane or to DONE. Flush overrides everything and returns to IDLE.
  always_comb begin
    state_d = state_q;
    class_d = class_q;
    mask_d  = mask_q;
    lane_d  = lane_q;
    advance = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          class_d = inClass;
          mask_d  = lane_mask;
          if (findFound) begin
            lane_d  = findNext;
            state_d = exec_state(inClass);
          end else begin
            lane_d  = '0;
            state_d = ST_DONE;
          end
        end
      end
      ST_VALU:    advance = 1'b1;
      ST_HIST_RD: state_d = ST_HIST_WR;
      ST_HIST_WR: advance = 1'b1;
      ST_MEM:     advance = mem_ack;
      ST_DONE: begin
        state_d = ST_IDLE;
        class_d = OP_NONE;
        mask_d  = '0;
        lane_d  = '0;
      end
      default:    state_d = ST_IDLE;
    endcase

    if (advance) begin
      if (findFound) begin
        lane_d  = findNext;
        state_d = (state_q == ST_HIST_WR) ? ST_HIST_RD : state_q;
      end else begin
        state_d = ST_DONE;
      end
    end

    if (flush) begin
      state_d = ST_IDLE;
      class_d = OP_NONE;
      mask_d  = '0;
      lane_d  = '0;
    end
  end

  // Output decode. The write-side strobes and done are blanked during a
  // flush cycle so an aborted instruction leaves no architectural trace;
  // the vector load only writes its lane when the data actually arrives.
  always_comb begin
    stall    = accept || ((state_q != ST_IDLE) && (state_q != ST_DONE));
    busy     = (state_q != ST_IDLE);
    lane_sel = lane_q;
    lane_we  = 1'b0;
    hist_rd  = 1'b0;
    hist_we  = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    done     = 1'b0;

    case (state_q)
      ST_VALU:    lane_we = !flush;
      ST_HIST_RD: hist_rd = 1'b1;
      ST_HIST_WR: hist_we = !flush;
      ST_MEM: begin
        mem_req = !flush;
        mem_we  = (class_q == OP_VST);
        lane_we = (class_q == OP_VLD) && mem_ack && !flush;
      end
      ST_DONE:    done = !flush;
      default:    ;
    endcase
  end

endmodule

// File: tb/tb_vector_lane_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vector_lane_sequencer
// Self-checking bench. A reference model turns (class, mask, ack delays)
// into a cycle-by-cycle list of expected outputs straight from the lane
// stepping rules; scenario tasks drive that list and compare each cycle.
// ---------------------------------------------------------------------------
module tb_vector_lane_sequencer;

  // Class codes used by the model
  localparam int C_NONE = 0;
  localparam int C_VALU = 1;
  localparam int C_VLD  = 2;
  localparam int C_VST  = 3;
  localparam int C_HIST = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid;
  logic       VectorWrite, HistogramWrite, MemWrite, MemtoReg;
  logic [7:0] lane_mask;
  logic       mem_ack;
  logic       flush;
  logic       stall, busy, lane_we, hist_rd, hist_we, mem_req, mem_we, done;
  logic [2:0] lane_sel;
  logic [7:0] obs;

  int compared   = 0;
  int mismatched = 0;

  // Packed view: {stall,busy,lane_we,hist_rd,hist_we,mem_req,mem_we,done}
  assign obs = {stall, busy, lane_we, hist_rd, hist_we, mem_req, mem_we, done};

  typedef struct {
    logic       iv;
    logic [3:0] ctl;   // {VectorWrite,HistogramWrite,MemWrite,MemtoReg}
    logic [7:0] mask;
    logic       ack;
    logic [7:0] exp;
    logic [2:0] lane;
    logic       lchk;
  } step_t;

  step_t trace[$];

  vector_lane_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid    (issue_valid),
    .VectorWrite    (VectorWrite),
    .HistogramWrite (HistogramWrite),
    .MemWrite       (MemWrite),
    .MemtoReg       (MemtoReg),
    .lane_mask      (lane_mask),
    .mem_ack        (mem_ack),
    .flush          (flush),
    .stall          (stall),
    .busy           (busy),
    .lane_sel       (lane_sel),
    .lane_we        (lane_we),
    .hist_rd        (hist_rd),
    .hist_we        (hist_we),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .done           (done)
  );

  always #5 clk = ~clk;

  // Hard time limit so the run always ends
  initial begin
    #400000;
    $display("[TB] FAIL timeout: simulation did not finish, got running, required finished");
    $fatal(1, "[TB] timeout");
  end

  // controlUnit encodings for a class; don't-care bits are randomized to
  // exercise the priority decode.
  function automatic logic [3:0] ctl_for(input int cls);
    logic [3:0] r;
    r = 4'($urandom);
    case (cls)
      C_VALU:  return 4'b1000;
      C_VLD:   return 4'b1001;
      C_VST:   return {r[3], 1'b0, 1'b1, r[0]};
      C_HIST:  return {r[3], 1'b1, r[1], r[0]};
      default: return {1'b0, 1'b0, 1'b0, r[0]};
    endcase
  endfunction

  function automatic step_t mk(input logic iv, input logic [3:0] ctl,
                               input logic [7:0] mask, input logic ack,
                               input logic [7:0] exp, input logic [2:0] lane,
                               input logic lchk);
    step_t s;
    s.iv = iv; s.ctl = ctl; s.mask = mask; s.ack = ack;
    s.exp = exp; s.lane = lane; s.lchk = lchk;
    return s;
  endfunction

  // Reference model: accept cycle, per-lane work, DONE, then one idle cycle.
  // Inputs other than mem_ack are scrambled while busy since they must not
  // matter; decode keeps the instruction valid through DONE.
  task automatic build_trace(input int cls, input logic [7:0] m, input int dly[8]);
    logic [3:0] ctl;
    logic isVld, isVst;
    ctl   = ctl_for(cls);
    isVld = (cls == C_VLD);
    isVst = (cls == C_VST);
    trace.delete();
    trace.push_back(mk(1'b1, ctl, m, 1'($urandom), 8'b1000_0000, 3'd0, 1'b0));
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        case (cls)
          C_VALU: trace.push_back(mk(1'b1, 4'($urandom), 8'($urandom), 1'($urandom),
                                     8'b1110_0000, 3'(i), 1'b1));
          C_HIST: begin
            trace.push_back(mk(1'b1, 4'($urandom), 8'($urandom), 1'($urandom),
                               8'b1101_0000, 3'(i), 1'b1));
            trace.push_back(mk(1'b1, 4'($urandom), 8'($urandom), 1'($urandom),
                               8'b1100_1000, 3'(i), 1'b1));
          end
          default: begin
            for (int w = 0; w < dly[i]; w++)
              trace.push_back(mk(1'b1, 4'($urandom), 8'($urandom), 1'b0,
                                 {2'b11, 1'b0, 2'b00, 1'b1, isVst, 1'b0}, 3'(i), 1'b1));
            trace.push_back(mk(1'b1, 4'($urandom), 8'($urandom), 1'b1,
                               {2'b11, isVld, 2'b00, 1'b1, isVst, 1'b0}, 3'(i), 1'b1));
          end
        endcase
      end
    end
    trace.push_back(mk(1'b1, ctl, m, 1'($urandom), 8'b0100_0001, 3'd0, 1'b0));
    trace.push_back(mk(1'b0, 4'($urandom), 8'($urandom), 1'($urandom), 8'b0000_0000, 3'd0, 1'b0));
  endtask

  // Plays one instruction against the model, comparing every cycle.
  task automatic test_instruction(input string name, input int cls,
                                  input logic [7:0] m, input int dly[8]);
    build_trace(cls, m, dly);
    foreach (trace[k]) begin
      @(posedge clk);
      #1;
      issue_valid = trace[k].iv;
      {VectorWrite, HistogramWrite, MemWrite, MemtoReg} = trace[k].ctl;
      lane_mask   = trace[k].mask;
      mem_ack     = trace[k].ack;
      flush       = 1'b0;
      #3;
      compared++;
      if (obs !== trace[k].exp) begin
        mismatched++;
        $display("[TB] FAIL %s cycle %0d outputs: got %b required %b", name, k, obs, trace[k].exp);
      end
      if (trace[k].lchk) begin
        compared++;
        if (lane_sel !== trace[k].lane) begin
          mismatched++;
          $display("[TB] FAIL %s cycle %0d lane_sel: got %0d required %0d",
                   name, k, lane_sel, trace[k].lane);
        end
      end
    end
  endtask

  // Reset state, then an asynchronous reset landing on lane 3 of a VALU.
  task automatic test_reset();
    rst = 1'b1;
    issue_valid = 1'b0;
    {VectorWrite, HistogramWrite, MemWrite, MemtoReg} = 4'b0000;
    lane_mask = 8'h00; mem_ack = 1'b0; flush = 1'b0;
    #12;
    compared++;
    if (obs !== 8'h00 || lane_sel !== 3'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_state: got %b/%0d required 00000000/0", obs, lane_sel);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    issue_valid = 1'b1;
    {VectorWrite, HistogramWrite, MemWrite, MemtoReg} = 4'b1000;
    lane_mask = 8'hFF;
    repeat (4) @(posedge clk);
    #2;
    compared++;
    if (lane_sel !== 3'd3 || lane_we !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_pre_lane3: got lane %0d we %b required lane 3 we 1", lane_sel, lane_we);
    end
    rst = 1'b1;
    #1;
    compared++;
    if (obs !== 8'h00 || lane_sel !== 3'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_async: got %b/%0d required 00000000/0", obs, lane_sel);
    end
    @(posedge clk); #1;
    issue_valid = 1'b0;
    rst = 1'b0;
    #2;
    compared++;
    if (obs !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL reset_release_idle: got %b required 00000000", obs);
    end
  endtask

  // Scalar instructions must never stall.
  task automatic test_scalar();
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      issue_valid = 1'b1;
      {VectorWrite, HistogramWrite, MemWrite, MemtoReg} = ctl_for(C_NONE);
      lane_mask = 8'($urandom);
      mem_ack   = 1'($urandom);
      #3;
      compared++;
      if (obs !== 8'h00) begin
        mismatched++;
        $display("[TB] FAIL scalar cycle %0d: got %b required 00000000", c, obs);
      end
    end
    @(posedge clk); #1 issue_valid = 1'b0;
  endtask

  // Flush while the store on lane 2 is waiting for its ack, then a flush
  // colliding with an accept.
  task automatic test_flush();
    @(posedge clk); #1;
    issue_valid = 1'b1;
    {VectorWrite, HistogramWrite, MemWrite, MemtoReg} = 4'b0010;
    lane_mask = 8'b0000_0110; mem_ack = 1'b0; flush = 1'b0;
    @(posedge clk); #1 mem_ack = 1'b1;
    #2;
    compared++;
    if (mem_req !== 1'b1 || lane_sel !== 3'd1) begin
      mismatched++;
      $display("[TB] FAIL flush_lane1: got req %b lane %0d required req 1 lane 1", mem_req, lane_sel);
    end
    @(posedge clk); #1 mem_ack = 1'b0;
    #2;
    compared++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || lane_sel !== 3'd2) begin
      mismatched++;
      $display("[TB] FAIL flush_lane2: got req %b we %b lane %0d required 1 1 2", mem_req, mem_we, lane_sel);
    end
    @(posedge clk); #1 flush = 1'b1;
    #2;
    compared++;
    if ({lane_we, hist_we, mem_req, done} !== 4'b0000 || busy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL flush_gate: got we/hw/req/done %b busy %b required 0000 busy 1",
               {lane_we, hist_we, mem_req, done}, busy);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    issue_valid = 1'b0;
    #2;
    compared++;
    if (obs !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL flush_idle: got %b required 00000000", obs);
    end
    @(posedge clk); #3;
    compared++;
    if (obs !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL flush_no_done: got %b required 00000000", obs);
    end
    #1;
    @(posedge clk); #1;
    issue_valid = 1'b1;
    {VectorWrite, HistogramWrite, MemWrite, MemtoReg} = 4'b1000;
    lane_mask = 8'hFF; flush = 1'b1;
    #2;
    compared++;
    if (stall !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL flush_accept_stall: got %b required 0", stall);
    end
    @(posedge clk); #1;
    issue_valid = 1'b0; flush = 1'b0;
    #2;
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL flush_accept_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_random();
    int d[8];
    int cls;
    for (int n = 0; n < 30; n++) begin
      cls = 1 + int'($urandom_range(3));
      for (int i = 0; i < 8; i++) d[i] = int'($urandom_range(3));
      test_instruction("random", cls, 8'($urandom), d);
    end
  endtask

  initial begin
    int d0[8];
    int d2[8];
    for (int i = 0; i < 8; i++) begin
      d0[i] = 0;
      d2[i] = 2;
    end
    test_reset();
    test_instruction("valu_a5",   C_VALU, 8'b1010_0101, d0);
    test_instruction("hist_03",   C_HIST, 8'b0000_0011, d0);
    test_instruction("vld_81",    C_VLD,  8'b1000_0001, d2);
    test_instruction("vst_3c",    C_VST,  8'b0011_1100, d0);
    test_instruction("valu_zero", C_VALU, 8'h00, d0);
    test_instruction("hist_80",   C_HIST, 8'h80, d0);
    test_scalar();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
